// File: rtl/pkt_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter: beat layout,
// FSM states and the round-robin pick.
package pkt_arb_pkg;

  localparam int PKT_NUM_SRC    = 4;
  localparam int PKT_SRC_W      = 2;
  localparam int PKT_DATA_WIDTH = 256;
  localparam int PKT_MAX_SRC    = 32;
  localparam int PKT_MAX_SRC_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic                      lw;
    logic [PKT_SRC_W-1:0]      src;
    logic [PKT_DATA_WIDTH-1:0] pld;
  } beat_t;

  // First set bit of avail at or above ptr, wrapping modulo n (n a power of 2).
  function automatic int unsigned rr_pick(input logic [PKT_MAX_SRC-1:0] avail,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned              pick;
    logic                     found;
    logic [PKT_MAX_SRC_W-1:0] idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < PKT_MAX_SRC; k++) begin
      idx = PKT_MAX_SRC_W'((ptr + k) & (n - 1));
      if (!found && (k < n) && avail[idx]) begin
        pick  = 32'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pkt_out_buf.sv
// Two-entry registered FIFO between the source pulls and the downstream port.
// Entry 0 is always the head, so the output is a plain register.
module pkt_out_buf
  import pkt_arb_pkg::*;
#(
  parameter type entry_t = beat_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  entry_t     push_data_i,
  input  logic       pop_rdy_i,
  output logic       vld_o,
  output entry_t     head_o,
  output logic [1:0] cnt_o
);

  entry_t     e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pop;

  assign pop = (cnt_q != 2'd0) && pop_rdy_i;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case ({push_i, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = push_data_i;
        else               e1_d = push_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = push_data_i;
        end else begin
          e0_d = e1_q;
          e1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign vld_o  = (cnt_q != 2'd0);
  assign head_o = e0_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/pkt_rr_arb.sv
// Packet-level round-robin arbiter: grants one source per packet, pulls it
// beat by beat until last-word, and forwards beats through a 2-entry buffer.
module pkt_rr_arb
  import pkt_arb_pkg::*;
#(
  parameter int NUM_SRC    = PKT_NUM_SRC,
  parameter int SRC_W      = PKT_SRC_W,
  parameter int DATA_WIDTH = PKT_DATA_WIDTH,
  parameter int MAX_BEATS  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_avail,
  output logic [NUM_SRC-1:0]            src_rdata_en,
  input  logic [NUM_SRC-1:0]            src_req,
  input  logic [NUM_SRC-1:0]            src_lw,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_pld,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic                          out_lw,
  output logic [SRC_W-1:0]              out_src,
  output logic [DATA_WIDTH-1:0]         out_pld,
  output logic                          err_overlen,
  output state_e                        dbg_state
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef struct packed {
    logic                  lw;
    logic [SRC_W-1:0]      src;
    logic [DATA_WIDTH-1:0] pld;
  } arb_beat_t;

  state_e           state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;

  logic             pull;
  logic             pull_lw;
  logic             grant_now;
  logic [1:0]       buf_cnt;
  arb_beat_t        push_beat;
  arb_beat_t        head;

  // Handshakes: a source beat moves when src_rdata_en[i] & src_req[i] (same
  // cycle); an output beat moves when out_vld & out_rdy. The pull strobe
  // depends only on registered state, never on out_rdy.
  assign pull      = |(src_rdata_en & src_req);
  assign pull_lw   = src_lw[grant_q];
  assign grant_now = (state_q == IDLE) && (|src_avail);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (grant_now) begin
          grant_d    = SRC_W'(rr_pick(PKT_MAX_SRC'(src_avail), 32'(rr_ptr_q), NUM_SRC));
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (pull) begin
          if (beat_cnt_q != CNT_W'(MAX_BEATS)) beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (!pull_lw && (beat_cnt_q == CNT_W'(MAX_BEATS - 1))) err_d = 1'b1;
          if (pull_lw) begin
            state_d  = IDLE;
            rr_ptr_d = grant_q + SRC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src_rdata_en = '0;
    if ((state_q == BUSY) && (buf_cnt != 2'd2)) src_rdata_en[grant_q] = 1'b1;
  end

  assign push_beat.lw  = pull_lw;
  assign push_beat.src = grant_q;
  assign push_beat.pld = src_pld[grant_q*DATA_WIDTH +: DATA_WIDTH];

  pkt_out_buf #(
    .entry_t (arb_beat_t)
  ) u_out_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (pull),
    .push_data_i (push_beat),
    .pop_rdy_i   (out_rdy),
    .vld_o       (out_vld),
    .head_o      (head),
    .cnt_o       (buf_cnt)
  );

  assign out_lw      = head.lw;
  assign out_src     = head.src;
  assign out_pld     = head.pld;
  assign err_overlen = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Bench for pkt_rr_arb: behavioural sources, a packet-order reference model
// and a beat scoreboard, plus directed timing checks.
module tb_pkt_rr_arb;
  import pkt_arb_pkg::*;

  localparam int NS = 4;
  localparam int SW = 2;
  localparam int DW = 256;
  localparam int MB = 4;
  localparam int BW = 1 + SW + DW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NS-1:0]    src_avail, src_rdata_en, src_req, src_lw;
  logic [NS*DW-1:0] src_pld;
  logic             out_vld, out_rdy, out_lw, err_overlen;
  logic [SW-1:0]    out_src;
  logic [DW-1:0]    out_pld;
  state_e           dbg_state;

  always #5 clk = ~clk;

  pkt_rr_arb #(
    .NUM_SRC    (NS),
    .SRC_W      (SW),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_avail    (src_avail),
    .src_rdata_en (src_rdata_en),
    .src_req      (src_req),
    .src_lw       (src_lw),
    .src_pld      (src_pld),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_lw       (out_lw),
    .out_src      (out_src),
    .out_pld      (out_pld),
    .err_overlen  (err_overlen),
    .dbg_state    (dbg_state)
  );

  // Source model: each source holds queued beats {lw, pld}.
  logic [DW:0]   sq [NS][$];
  int            pkts [NS];
  logic [BW-1:0] exp_q [$];
  int            model_order [$];
  int            obs_order [$];
  int            m_ptr;
  int            n_checks, n_errors;
  int            stall_pct, rdy_pct;
  bit            in_pkt;
  int            delivered;
  int            cyc;
  int            lg_pull_cyc [$];
  state_e        lg_state [$];
  logic [NS-1:0] lg_en [$];
  logic          lg_err [$];
  logic          lg_vld [$];
  logic [NS-1:0] pend_pull;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_pld();
    logic [DW-1:0] p;
    p = '0;
    for (int w = 0; w < DW / 32; w++) p = {p[DW-33:0], 32'($urandom())};
    return p;
  endfunction

  task automatic load_pkt(input int s, input int nb, input int lw_at);
    for (int b = 1; b <= nb; b++) sq[s].push_back({(b == lw_at), rnd_pld()});
    pkts[s]++;
  endtask

  // Reference: packets leave whole, in round-robin order starting after the
  // last source served; payloads go out unchanged tagged with their source.
  task automatic plan();
    logic [DW:0] cq [NS][$];
    logic [DW:0] b;
    int          s;
    for (int i = 0; i < NS; i++) cq[i] = sq[i];
    model_order.delete();
    while (1) begin
      s = -1;
      for (int k = 0; k < NS; k++) begin
        if (s < 0 && cq[(m_ptr + k) % NS].size() > 0) s = (m_ptr + k) % NS;
      end
      if (s < 0) break;
      model_order.push_back(s);
      do begin
        b = cq[s].pop_front();
        exp_q.push_back({b[DW], SW'(s), b[DW-1:0]});
      end while (!b[DW]);
      m_ptr = (s + 1) % NS;
    end
  endtask

  task automatic drive();
    logic [DW:0] hd;
    for (int i = 0; i < NS; i++) begin
      src_avail[i] = (pkts[i] != 0);
      if (sq[i].size() > 0) begin
        hd = sq[i][0];
        src_pld[i*DW +: DW] = hd[DW-1:0];
        src_lw[i]  = hd[DW];
        src_req[i] = ($urandom_range(99) >= stall_pct);
      end else begin
        src_pld[i*DW +: DW] = '0;
        src_lw[i]  = 1'b0;
        src_req[i] = 1'b0;
      end
    end
    out_rdy = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic run_cycles(input int n);
    logic [DW:0] tmp;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (pend_pull[i]) begin
          tmp = sq[i].pop_front();
          if (tmp[DW]) pkts[i]--;
        end
      end
      drive();
      #1;
      pend_pull = src_rdata_en & src_req;
      lg_state.push_back(dbg_state);
      lg_en.push_back(src_rdata_en);
      lg_err.push_back(err_overlen);
      lg_vld.push_back(out_vld);
      if (pend_pull != '0) begin
        lg_pull_cyc.push_back(cyc);
        for (int i = 0; i < NS; i++) begin
          if (pend_pull[i]) begin
            if (!in_pkt) obs_order.push_back(i);
            in_pkt = !src_lw[i];
          end
        end
      end
      if (out_vld && out_rdy) begin
        delivered++;
        chk("sb_nonempty", BW'(exp_q.size() != 0), BW'(1));
        if (exp_q.size() != 0) chk("beat", {out_lw, out_src, out_pld}, exp_q.pop_front());
      end
      cyc++;
    end
  endtask

  function automatic bit all_done();
    bit d;
    d = (exp_q.size() == 0) && (pend_pull == '0);
    for (int i = 0; i < NS; i++) if (sq[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!all_done() && k < budget) begin
      run_cycles(1);
      k++;
    end
    chk({tag, "_done"}, BW'(all_done()), BW'(1));
  endtask

  task automatic clear_logs();
    lg_pull_cyc.delete();
    lg_state.delete();
    lg_en.delete();
    lg_err.delete();
    lg_vld.delete();
    obs_order.delete();
    delivered = 0;
    cyc = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            span, idle_cnt, en_cnt, vld_cnt, first_vld, n_beats, n;
    logic [DW-1:0] b0;
    n_checks = 0; n_errors = 0;
    stall_pct = 0; rdy_pct = 100;
    pend_pull = '0; in_pkt = 1'b0; m_ptr = 0;
    for (int i = 0; i < NS; i++) pkts[i] = 0;
    rst_n = 1'b0;
    src_avail = '0; src_req = '0; src_lw = '0; src_pld = '0; out_rdy = 1'b0;
    clear_logs();

    repeat (2) @(negedge clk);
    #1;
    chk("rst_vld", BW'(out_vld), BW'(0));
    chk("rst_en", BW'(src_rdata_en), BW'(0));
    chk("rst_err", BW'(err_overlen), BW'(0));
    chk("rst_lw_src", BW'({out_lw, out_src}), BW'(0));
    chk("rst_pld", BW'(out_pld), BW'(0));
    chk("rst_state", BW'(dbg_state), BW'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin: all sources hold two 2-beat packets.
    clear_logs();
    for (int s = 0; s < NS; s++) begin
      load_pkt(s, 2, 2);
      load_pkt(s, 2, 2);
    end
    plan();
    run_until_done("rr", 200);
    chk("rr_ngrants", BW'(obs_order.size()), BW'(8));
    for (int k = 0; k < obs_order.size() && k < 8; k++)
      chk("rr_grant", BW'(obs_order[k]), BW'(model_order[k]));
    if (obs_order.size() > 0) chk("rr_first", BW'(obs_order[0]), BW'(0));
    chk("rr_npulls", BW'(lg_pull_cyc.size()), BW'(16));
    if (lg_pull_cyc.size() == 16) begin
      span = lg_pull_cyc[15] - lg_pull_cyc[0] + 1;
      chk("rr_span", BW'(span), BW'(16 + 7));
      idle_cnt = 0;
      for (int c = lg_pull_cyc[0]; c < lg_pull_cyc[15]; c++) if (lg_state[c] == IDLE) idle_cnt++;
      chk("rr_idle", BW'(idle_cnt), BW'(7));
    end

    // Single source, 3 beats.
    clear_logs();
    load_pkt(1, 3, 3);
    plan();
    run_until_done("single", 50);
    run_cycles(1);
    en_cnt = 0; vld_cnt = 0; first_vld = -1;
    for (int c = 0; c < cyc; c++) begin
      if (lg_en[c] == 4'b0010) en_cnt++;
      if (lg_vld[c]) begin
        vld_cnt++;
        if (first_vld < 0) first_vld = c;
      end
    end
    chk("single_en", BW'(en_cnt), BW'(3));
    chk("single_vld", BW'(vld_cnt), BW'(3));
    if (lg_pull_cyc.size() > 0) chk("single_lat", BW'(first_vld), BW'(lg_pull_cyc[0] + 1));
    chk("single_idle", BW'(dbg_state), BW'(IDLE));
    if (obs_order.size() > 0) chk("single_src", BW'(obs_order[0]), BW'(1));

    // Backpressure on a 4-beat packet.
    clear_logs();
    rdy_pct = 0;
    load_pkt(2, 4, 4);
    b0 = sq[2][0][DW-1:0];
    plan();
    run_cycles(6);
    chk("bp_pulls", BW'(lg_pull_cyc.size()), BW'(2));
    chk("bp_en", BW'(src_rdata_en), BW'(0));
    chk("bp_busy", BW'(dbg_state), BW'(BUSY));
    for (int k = 0; k < 3; k++) begin
      run_cycles(1);
      chk("bp_hold", BW'({out_vld, out_pld}), BW'({1'b1, b0}));
    end
    rdy_pct = 100;
    run_until_done("bp", 50);
    chk("bp_deliv", BW'(delivered), BW'(4));
    chk("bp_pulls_all", BW'(lg_pull_cyc.size()), BW'(4));

    // Request gap mid-packet.
    clear_logs();
    load_pkt(3, 4, 4);
    plan();
    run_cycles(3);
    stall_pct = 100;
    run_cycles(2);
    chk("gap_pulls", BW'(lg_pull_cyc.size()), BW'(2));
    chk("gap_busy0", BW'(lg_state[3]), BW'(BUSY));
    chk("gap_busy1", BW'(lg_state[4]), BW'(BUSY));
    stall_pct = 0;
    run_until_done("gap", 50);
    chk("gap_deliv", BW'(delivered), BW'(4));
    chk("err_legal", BW'(err_overlen), BW'(0));

    // Overlength: 5 beats with MAX_BEATS=4.
    clear_logs();
    load_pkt(0, 5, 5);
    plan();
    run_until_done("ovl", 50);
    run_cycles(3);
    chk("ovl_pulls", BW'(lg_pull_cyc.size()), BW'(5));
    if (lg_pull_cyc.size() == 5) begin
      chk("ovl_pre", BW'(lg_err[lg_pull_cyc[2]]), BW'(0));
      chk("ovl_set", BW'(lg_err[lg_pull_cyc[3] + 1]), BW'(1));
    end
    chk("ovl_sticky", BW'(err_overlen), BW'(1));
    chk("ovl_deliv", BW'(delivered), BW'(5));

    // Reset mid-packet with one beat buffered.
    clear_logs();
    load_pkt(2, 4, 4);
    plan();
    run_cycles(3);
    chk("rm_vld_pre", BW'(out_vld), BW'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rm_vld", BW'(out_vld), BW'(0));
    chk("rm_en", BW'(src_rdata_en), BW'(0));
    chk("rm_err", BW'(err_overlen), BW'(0));
    for (int i = 0; i < NS; i++) begin
      sq[i].delete();
      pkts[i] = 0;
    end
    exp_q.delete();
    pend_pull = '0; in_pkt = 1'b0; m_ptr = 0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    load_pkt(1, 2, 2);
    load_pkt(3, 2, 2);
    plan();
    run_until_done("rm", 50);
    if (obs_order.size() > 0) chk("rm_first", BW'(obs_order[0]), BW'(1));

    // Randomized traffic with stalls and backpressure.
    stall_pct = 20;
    rdy_pct = 70;
    for (int r = 0; r < 4; r++) begin
      clear_logs();
      n_beats = 0;
      for (int s = 0; s < NS; s++) begin
        repeat ($urandom_range(4)) begin
          n = $urandom_range(1, MB);
          load_pkt(s, n, n);
          n_beats += n;
        end
      end
      plan();
      run_until_done("rand", 3000);
      chk("rand_deliv", BW'(delivered), BW'(n_beats));
      chk("rand_order", BW'(obs_order.size()), BW'(model_order.size()));
      chk("rand_err", BW'(err_overlen), BW'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
